// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and master-controller-side signals around the I2C transaction arbiter.
// The arbiter binds to the slave modport; requesters and the master controller use the master modport.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_rw;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_err;
    logic [7:0]        rsp_rdata;
    logic              busy;
    logic              m_new_data;
    logic              m_rw_bar;
    logic [6:0]        m_addr;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;
    logic              m_done;

    modport slave (
        input  req, req_rw, req_addr, req_wdata, m_rdata, m_done,
        output gnt, req_done, req_err, rsp_rdata, busy,
               m_new_data, m_rw_bar, m_addr, m_wdata
    );

    modport master (
        output req, req_rw, req_addr, req_wdata, m_rdata, m_done,
        input  gnt, req_done, req_err, rsp_rdata, busy,
               m_new_data, m_rw_bar, m_addr, m_wdata
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master controller among NREQ requesters,
// issuing one byte transaction at a time with timeout recovery and a post-timeout idle guard.
module i2c_txn_arbiter #(
    parameter int NREQ      = 4,
    parameter int ISSUE_CYC = 24,
    parameter int TIMEOUT   = 4096,
    parameter int GUARD     = 64
) (
    input  logic              clk,
    input  logic              reset,
    i2c_txn_arbiter_if.slave  bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ISS_W = $clog2(ISSUE_CYC);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int GRD_W = $clog2(GUARD);

    localparam logic [ISS_W-1:0] ISS_LAST  = ISS_W'(ISSUE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_PRE    = TO_W'(TIMEOUT - 2);
    localparam logic [GRD_W-1:0] GRD_LAST  = GRD_W'(GUARD - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE,
        S_GUARD
    } state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   req_done_q;
    logic [NREQ-1:0]   req_err_q;
    logic [7:0]        rsp_rdata_q;
    logic              busy_q;
    logic              m_new_data_q;
    logic              m_rw_bar_q;
    logic [6:0]        m_addr_q;
    logic [7:0]        m_wdata_q;
    logic [ISS_W-1:0]  issue_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [GRD_W-1:0]  guard_cnt_q;
    logic              done_q;
    logic              pend_q;

    logic              win_found_d;
    logic [PTR_W-1:0]  win_idx_d;
    logic [PTR_W-1:0]  ptr_next_d;
    logic [NREQ-1:0]   win_onehot_d;
    logic              done_rise_d;
    int                cand_d;

    // Round-robin search: the first asserted request at or after rr_ptr_q, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        win_found_d  = 1'b0;
        win_idx_d    = '0;
        cand_d       = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_d = (int'(rr_ptr_q) + i) % NREQ;
            if (!win_found_d && bus.req[cand_d]) begin
                win_found_d = 1'b1;
                win_idx_d   = PTR_W'(cand_d);
            end
        end
        ptr_next_d   = (win_idx_d == PTR_LAST) ? '0 : win_idx_d + 1'b1;
        win_onehot_d = '0;
        win_onehot_d[win_idx_d] = 1'b1;
    end

    // Only a fresh 0->1 edge of m_done counts; a level left over from a prior transaction does not.
    assign done_rise_d = bus.m_done & ~done_q;

    // NOTE: all state and outputs are registered with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            rsp_rdata_q  <= 8'h00;
            busy_q       <= 1'b0;
            m_new_data_q <= 1'b0;
            m_rw_bar_q   <= 1'b0;
            m_addr_q     <= 7'h00;
            m_wdata_q    <= 8'h00;
            issue_cnt_q  <= '0;
            to_cnt_q     <= '0;
            guard_cnt_q  <= '0;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            done_q     <= bus.m_done;
            req_done_q <= '0;
            req_err_q  <= '0;

            case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        state_q      <= S_ISSUE;
                        gnt_q        <= win_onehot_d;
                        rr_ptr_q     <= ptr_next_d;
                        m_rw_bar_q   <= bus.req_rw[win_idx_d];
                        m_addr_q     <= bus.req_addr[int'(win_idx_d) * 7 +: 7];
                        m_wdata_q    <= bus.req_wdata[int'(win_idx_d) * 8 +: 8];
                        m_new_data_q <= 1'b1;
                        busy_q       <= 1'b1;
                        issue_cnt_q  <= '0;
                        pend_q       <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    // The controller may finish before the strobe window ends; remember it for WAIT.
                    if (done_rise_d) begin
                        pend_q <= 1'b1;
                    end
                    if (issue_cnt_q == ISS_LAST) begin
                        state_q      <= S_WAIT;
                        m_new_data_q <= 1'b0;
                        to_cnt_q     <= '0;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                end

                S_WAIT: begin
                    // The error pulse is already out in the last WAIT cycle, so timeout wins any late edge.
                    if (to_cnt_q == TO_LAST) begin
                        state_q     <= S_GUARD;
                        gnt_q       <= '0;
                        guard_cnt_q <= '0;
                        pend_q      <= 1'b0;
                    end else if (done_rise_d || pend_q) begin
                        state_q    <= S_COMPLETE;
                        req_done_q <= gnt_q;
                        pend_q     <= 1'b0;
                        if (m_rw_bar_q) begin
                            rsp_rdata_q <= bus.m_rdata;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (to_cnt_q == TO_PRE) begin
                            req_err_q <= gnt_q;
                        end
                    end
                end

                S_COMPLETE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end

                S_GUARD: begin
                    pend_q <= 1'b0;
                    if (guard_cnt_q == GRD_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    gnt_q        <= '0;
                    busy_q       <= 1'b0;
                    m_new_data_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.req_done   = req_done_q;
    assign bus.req_err    = req_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.busy       = busy_q;
    assign bus.m_new_data = m_new_data_q;
    assign bus.m_rw_bar   = m_rw_bar_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter: write, read, stale done, timeout/guard,
// round-robin fairness and mid-transaction reset.
module tb_i2c_txn_arbiter;
    localparam int NREQ      = 4;
    localparam int ISSUE_CYC = 24;
    localparam int TIMEOUT   = 4096;
    localparam int GUARD     = 64;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_txn_arbiter #(
        .NREQ(NREQ), .ISSUE_CYC(ISSUE_CYC), .TIMEOUT(TIMEOUT), .GUARD(GUARD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // From the first ISSUE cycle: run out the strobe, return m_done, expect the completion pulse.
    task automatic complete_txn(input string tag, input logic [3:0] exp_gnt);
        repeat (ISSUE_CYC) tick();
        bus.m_done = 1'b1;
        tick();
        check({tag, " req_done"}, bus.req_done, exp_gnt);
        bus.m_done = 1'b0;
        tick();
        check({tag, " gnt clear"}, bus.gnt, 4'b0000);
    endtask

    task automatic do_txn(input string tag, input logic [3:0] exp_gnt);
        tick();
        check({tag, " gnt"}, bus.gnt, exp_gnt);
        complete_txn(tag, exp_gnt);
    endtask

    initial begin
        int cnt;
        int bad;
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_rdata   = 8'h00;
        bus.m_done    = 1'b0;
        repeat (3) tick();

        check("reset gnt",        bus.gnt,        4'b0000);
        check("reset busy",       bus.busy,       1'b0);
        check("reset m_new_data", bus.m_new_data, 1'b0);
        check("reset rsp_rdata",  bus.rsp_rdata,  8'h00);
        check("reset m_addr",     bus.m_addr,     7'h00);
        check("reset m_wdata",    bus.m_wdata,    8'h00);
        reset = 1'b0;
        tick();

        // Single write from requester 0; req dropped right after grant must not abort it.
        bus.req            = 4'b0001;
        bus.req_rw         = 4'b0000;
        bus.req_addr[6:0]  = 7'h50;
        bus.req_wdata[7:0] = 8'hA5;
        tick();
        check("wr gnt",        bus.gnt,        4'b0001);
        check("wr m_new_data", bus.m_new_data, 1'b1);
        check("wr m_addr",     bus.m_addr,     7'h50);
        check("wr m_wdata",    bus.m_wdata,    8'hA5);
        check("wr m_rw_bar",   bus.m_rw_bar,   1'b0);
        check("wr busy",       bus.busy,       1'b1);
        bus.req = 4'b0000;
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.m_new_data) cnt++;
            else break;
        end
        check("wr strobe length", cnt, ISSUE_CYC);
        check("wr gnt in wait",   bus.gnt, 4'b0001);
        repeat (3) tick();
        bus.m_done = 1'b1;
        tick();
        check("wr req_done",   bus.req_done, 4'b0001);
        check("wr gnt at done", bus.gnt,     4'b0001);
        tick();
        check("wr done pulse width", bus.req_done, 4'b0000);
        check("wr gnt clear",        bus.gnt,      4'b0000);
        check("wr busy clear",       bus.busy,     1'b0);

        // Read from requester 2 with m_done still high from the write: stale level must be ignored.
        bus.req              = 4'b0100;
        bus.req_rw           = 4'b0100;
        bus.req_addr[20:14]  = 7'h12;
        bus.m_rdata          = 8'h3C;
        tick();
        check("rd gnt",      bus.gnt,      4'b0100);
        check("rd m_rw_bar", bus.m_rw_bar, 1'b1);
        check("rd m_addr",   bus.m_addr,   7'h12);
        bus.req = 4'b0000;
        repeat (ISSUE_CYC + 10) tick();
        check("stale no done", bus.req_done, 4'b0000);
        check("stale gnt held", bus.gnt,     4'b0100);
        bus.m_done = 1'b0;
        tick();
        bus.m_done = 1'b1;
        tick();
        check("rd req_done",  bus.req_done,  4'b0100);
        check("rd rsp_rdata", bus.rsp_rdata, 8'h3C);
        bus.m_done = 1'b0;
        tick();
        check("rd gnt clear", bus.gnt, 4'b0000);

        // Write follow-up from requester 2 must leave rsp_rdata alone.
        bus.req     = 4'b0100;
        bus.req_rw  = 4'b0000;
        bus.m_rdata = 8'h77;
        tick();
        check("wr2 gnt",      bus.gnt,      4'b0100);
        check("wr2 m_rw_bar", bus.m_rw_bar, 1'b0);
        bus.req = 4'b0000;
        complete_txn("wr2", 4'b0100);
        check("wr2 rsp_rdata kept", bus.rsp_rdata, 8'h3C);

        // Timeout: rr_ptr is 3, so requester 0 wins; no m_done ever arrives.
        bus.req = 4'b0001;
        tick();
        check("to gnt", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        repeat (ISSUE_CYC) tick();
        repeat (TIMEOUT - 2) tick();
        check("to no early err", bus.req_err, 4'b0000);
        tick();
        check("to req_err",      bus.req_err, 4'b0001);
        check("to gnt at err",   bus.gnt,     4'b0001);
        tick();
        check("to err pulse width", bus.req_err, 4'b0000);
        bus.req = 4'b0010;
        bad = 0;
        for (int i = 0; i < GUARD; i++) begin
            if (i == 10) bus.m_done = 1'b1;
            if (i == 20) bus.m_done = 1'b0;
            if (bus.gnt !== 4'b0000 || bus.m_new_data !== 1'b0 ||
                bus.req_done !== 4'b0000 || bus.busy !== 1'b1) bad++;
            tick();
        end
        check("guard quiet cycles", bad, 0);
        check("guard end idle busy", bus.busy, 1'b0);
        check("guard end idle gnt",  bus.gnt,  4'b0000);
        tick();
        check("post-guard gnt", bus.gnt, 4'b0010);
        bus.req = 4'b0000;
        complete_txn("post-guard", 4'b0010);

        // Fairness after reset: rr_ptr back to 0, all four requesting continuously.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.req_addr = {7'h23, 7'h22, 7'h21, 7'h20};
        bus.req_rw   = 4'b0000;
        bus.req      = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            do_txn($sformatf("rr%0d", k), 4'b0001 << (k % 4));
            check($sformatf("rr%0d m_addr", k), bus.m_addr, 7'h20 + 7'(k % 4));
        end
        bus.req = 4'b0000;
        tick();

        // Reset asserted in WAIT: outputs clear without waiting for a clock edge.
        bus.req = 4'b0001;
        tick();
        check("rst gnt before", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        repeat (ISSUE_CYC + 6) tick();
        check("rst in wait busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst async gnt",       bus.gnt,        4'b0000);
        check("rst async busy",      bus.busy,       1'b0);
        check("rst async req_done",  bus.req_done,   4'b0000);
        check("rst async req_err",   bus.req_err,    4'b0000);
        check("rst async m_new",     bus.m_new_data, 1'b0);
        check("rst async m_addr",    bus.m_addr,     7'h00);
        check("rst async rsp_rdata", bus.rsp_rdata,  8'h00);
        bus.req = 4'b1010;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post-rst gnt", bus.gnt, 4'b0010);
        check("post-rst no pulses", {bus.req_done, bus.req_err}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
